// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: five-stage pipeline stall, flush and forwarding control with a memory-wait timeout trap
module pipeline_hazard_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic [4:0]  rdM,
  input  logic [4:0]  rdW,
  input  logic [1:0]  ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        memReqM,
  input  logic        memReadyM,
  output logic        enF,
  output logic        enD,
  output logic        enE,
  output logic        enM,
  output logic        enW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        memTimeout,
  output logic [31:0] stallCycles
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state, state_n;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic err, mem_stall, lw_stall, hold;
  always_comb begin
    ForwardAE = (RegWriteM && rdM != 5'd0 && rdM == rs1E) ? 2'b10 :
                (RegWriteW && rdW != 5'd0 && rdW == rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && rdM != 5'd0 && rdM == rs2E) ? 2'b10 :
                (RegWriteW && rdW != 5'd0 && rdW == rs2E) ? 2'b01 : 2'b00;
  end
  always_comb begin
    err       = state == ERROR;
    mem_stall = memReqM && !memReadyM && !err;
    lw_stall  = ResultSrcE == 2'b01 && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    hold      = err || mem_stall;
    // a taken branch squashes the ID instruction, so it overrides a load-use stall
    enF    = !hold && (PCSrcE || !lw_stall);
    enD    = !hold && (PCSrcE || !lw_stall);
    enE    = !hold;
    enM    = !hold;
    enW    = !err;
    flushD = !hold && PCSrcE;
    flushE = !hold && (PCSrcE || lw_stall);
    flushW = mem_stall;
  end
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      RUN: begin
        state_n    = mem_stall ? MEM_WAIT : RUN;
        wait_cnt_n = mem_stall ? 8'd1 : wait_cnt;
      end
      MEM_WAIT: begin
        if (memReadyM || !memReqM) begin
          state_n    = RUN;
          wait_cnt_n = 8'd0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          state_n = ERROR;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      ERROR: state_n = ERROR;
      default: begin
        state_n    = RUN;
        wait_cnt_n = 8'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      memTimeout  <= 1'b0;
      stallCycles <= 32'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (state_n == ERROR)
        memTimeout <= 1'b1;
      if (!err && (mem_stall || lw_stall) && stallCycles != 32'hFFFF_FFFF)
        stallCycles <= stallCycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: scoreboard-driven scenario bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, memReqM, memReadyM;
  logic enF, enD, enE, enM, enW, flushD, flushE, flushW, memTimeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] stallCycles;

  pipeline_hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW), .flushD(flushD),
    .flushE(flushE), .flushW(flushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .memTimeout(memTimeout), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  // {enF,enD,enE,enM,enW, flushD,flushE,flushW, ForwardAE,ForwardBE, memTimeout}
  wire [12:0] obs = {enF, enD, enE, enM, enW, flushD, flushE, flushW, ForwardAE, ForwardBE, memTimeout};
  localparam logic [12:0] IDLE = 13'b11111_000_0000_0;
  localparam logic [12:0] LW   = 13'b00111_010_0000_0;
  localparam logic [12:0] BR   = 13'b11111_110_0000_0;
  localparam logic [12:0] MEM  = 13'b00001_001_0000_0;
  localparam logic [12:0] ERR  = 13'b00000_000_0000_1;

  typedef struct packed {
    logic        rst;
    logic [1:0]  rsrc;
    logic [4:0]  rde;
    logic [4:0]  rs1d;
    logic [4:0]  rs2d;
    logic        pc;
    logic        req;
    logic        rdy;
    logic [12:0] o;
    logic        inc;
  } step_t;

  localparam step_t RST = '{1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0};
  localparam step_t IDL = '{0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0};
  localparam step_t MW  = '{0, 0, 0, 0, 0, 0, 1, 0, MEM, 1};
  localparam step_t MWB = '{0, 0, 0, 0, 0, 1, 1, 0, MEM, 1};
  localparam step_t ER  = '{0, 0, 0, 0, 0, 0, 1, 0, ERR, 0};

  typedef struct {
    string       name;
    logic [12:0] o;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_sc = 32'd0;

  task automatic apply(input step_t s);
    reset      = s.rst;
    ResultSrcE = s.rsrc;
    rdE        = s.rde;
    rs1D       = s.rs1d;
    rs2D       = s.rs2d;
    PCSrcE     = s.pc;
    memReqM    = s.req;
    memReadyM  = s.rdy;
  endtask

  task automatic test_reset();
    step_t s [2];
    s = '{RST, IDL};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("reset[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  localparam logic [4:0] FM  [6] = '{5, 5, 0, 5, 5, 6};
  localparam logic [4:0] FW  [6] = '{5, 5, 0, 5, 5, 5};
  localparam logic [4:0] F1  [6] = '{5, 5, 0, 0, 0, 6};
  localparam logic [4:0] F2  [6] = '{0, 0, 0, 5, 5, 5};
  localparam logic       FRM [6] = '{1, 0, 1, 1, 0, 1};
  localparam logic [1:0] FA  [6] = '{2, 1, 0, 0, 0, 2};
  localparam logic [1:0] FB  [6] = '{0, 0, 0, 2, 1, 1};

  task automatic test_forwarding();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(IDL);
      rdM = FM[i]; rdW = FW[i]; rs1E = F1[i]; rs2E = F2[i];
      RegWriteM = FRM[i]; RegWriteW = 1'b1;
      sb.push_back('{$sformatf("forward[%0d]", i), {8'b11111_000, FA[i], FB[i], 1'b0}, exp_sc});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
      if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
    end
    @(negedge clk);
    rdM = 0; rdW = 0; rs1E = 0; rs2E = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic test_load_use();
    step_t s [6];
    s = '{'{0, 1, 7, 0, 7, 0, 0, 0, LW, 1}, IDL, '{0, 1, 0, 0, 0, 0, 0, 0, IDLE, 0},
          '{0, 2, 7, 7, 0, 0, 0, 0, IDLE, 0}, '{0, 1, 7, 7, 0, 0, 0, 0, LW, 1}, IDL};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("load_use[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  task automatic test_branch_lw();
    step_t s [3];
    s = '{'{0, 1, 3, 3, 0, 1, 0, 0, BR, 1}, '{0, 0, 0, 0, 0, 1, 0, 0, BR, 0}, IDL};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("branch_lw[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  task automatic test_mem_wait();
    step_t s [6];
    s = '{RST, MWB, MWB, MWB, '{0, 0, 0, 0, 0, 1, 1, 1, BR, 0}, IDL};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("mem_wait[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  task automatic test_timeout();
    step_t s [11];
    s = '{RST, MW, MW, MW, MW, MW, ER, ER, '{0, 0, 0, 0, 0, 0, 1, 1, ERR, 0},
          '{0, 1, 3, 3, 0, 1, 0, 0, ERR, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, ERR, 0}};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("timeout[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s [11];
    s = '{RST, MW, MW, '{0, 1, 4, 0, 4, 0, 1, 1, LW, 1}, MW, MW, MW, MW, MW, ER, RST};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("back_to_back[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s [15];
    s = '{RST, MW, MW, '{1, 0, 0, 0, 0, 0, 1, 0, MEM, 0}, IDL, MW, MW, MW, MW, MW, ER,
          '{1, 0, 0, 0, 0, 0, 1, 0, ERR, 0}, IDL, '{0, 1, 5, 5, 0, 0, 0, 0, LW, 1}, IDL};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(s[i]);
      if (s[i].rst) exp_sc = 32'd0;
      else begin
        sb.push_back('{$sformatf("reset_mid[%0d]", i), s[i].o, exp_sc});
        if (s[i].inc) exp_sc++;
        #1;
        e = sb.pop_front();
        checks += 2;
        if (obs !== e.o) begin errors++; $display("FAIL %s outputs got %b expected %b", e.name, obs, e.o); end
        if (stallCycles !== e.sc) begin errors++; $display("FAIL %s stallCycles got %0d expected %0d", e.name, stallCycles, e.sc); end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(RST);
    rs1E = 0; rs2E = 0; rdM = 0; rdW = 0; RegWriteM = 0; RegWriteW = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_lw();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Hazard and stall controller for the five-stage RISC-V pipeline. Drives the enable (we) and flush (synchronous reset) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Produces the EX-stage forwarding selects. Tracks a multi-cycle data-memory handshake with a timeout trap, and counts stall cycles for performance measurement.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive not-ready cycles tolerated in MEM_WAIT before entering ERROR (1..255); waitCnt is 8 bits wide.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rs1D, rs2D  input  5 each  source registers of the instruction in ID
rs1E, rs2E  input  5 each  source registers of the instruction in EX
rdE, rdM, rdW  input  5 each  destination registers in EX, MEM and WB
ResultSrcE  input  2  EX result source; 2'b01 = load
RegWriteM, RegWriteW  input  1 each  register-write flags in MEM and WB
PCSrcE  input  1  taken branch or jump resolved in EX
memReqM  input  1  load or store present in MEM
memReadyM  input  1  data memory completes the MEM access this cycle
enF, enD, enE, enM  output  1 each  PC, IF/ID, ID/EX and EX/MEM enables
enW  output  1  MEM/WB enable
flushD, flushE, flushW  output  1 each  IF/ID, ID/EX and MEM/WB flushes
ForwardAE, ForwardBE  output  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result
memTimeout  output  1  sticky memory-timeout error
stallCycles  output  32  saturating stall-cycle counter

Behaviour:
- Registered state: FSM {RUN, MEM_WAIT, ERROR}, waitCnt[7:0], memTimeout, stallCycles.
- On reset: state RUN, waitCnt 0, memTimeout 0, stallCycles 0. Reset takes priority over every other event, including when asserted mid-MEM_WAIT or in ERROR.
- Combinational outputs with idle inputs: all en* = 1, all flush* = 0, Forward* = 00.
- Forwarding (combinational; shown for A, B is identical using rs2E):
  - 10 if RegWriteM & rdM != 0 & rdM == rs1E;
  - else 01 if RegWriteW & rdW != 0 & rdW == rs1E;
  - else 00.
  - MEM has priority over WB.
- lwStall = (ResultSrcE == 01) & rdE != 0 & (rdE == rs1D | rdE == rs2D).
- memStall = memReqM & !memReadyM, combinational, valid in RUN and MEM_WAIT. The stall takes effect in the same cycle memReadyM is low.
- Output priority: ERROR > memStall > PCSrcE > lwStall.
  - ERROR: all en* = 0, all flush* = 0. The pipeline is frozen until reset.
  - memStall:
    - enF = enD = enE = enM = 0, enW = 1, flushW = 1 (a bubble enters WB; the MEM/WB register gives flush priority over enable).
    - flushD = flushE = 0; a taken branch in EX is held and resolves after the stall.
  - PCSrcE: flushD = flushE = 1, all en* = 1. This squashes the instruction in D, so any lwStall is ignored.
  - lwStall: enF = enD = 0, flushE = 1, other enables 1. Lasts exactly one cycle per load-use pair.
- FSM transitions:
  - RUN:
    - memStall -> MEM_WAIT, waitCnt <= 1;
    - otherwise stay.
  - MEM_WAIT:
    - if memReadyM or !memReqM -> RUN, waitCnt <= 0;
    - else if waitCnt == MEM_TIMEOUT -> ERROR, memTimeout <= 1;
    - else waitCnt <= waitCnt + 1.
  - ERROR: stays until reset; memTimeout held at 1.
- Timing: ERROR is entered after MEM_TIMEOUT+1 consecutive not-ready cycles. memTimeout is visible the cycle after the last one.
- stallCycles:
  - increments by 1 on every cycle where (memStall | lwStall) and state != ERROR;
  - does not count PCSrcE flush cycles;
  - saturates at 32'hFFFFFFFF with no wrap;
  - is frozen in ERROR.
- Simultaneous events:
  - memReadyM rising in the same cycle as a new lwStall: lwStall is applied in that cycle.
  - back-to-back memory accesses each re-enter MEM_WAIT with waitCnt restarting at 1.

Test Plan:
1. Forwarding: rdM = rdW = rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Then RegWriteM = 0 -> 01. Then rdM = rdW = rs1E = 0 -> 00. Repeat on ForwardBE via rs2E.
2. Load-use: ResultSrcE = 01, rdE = 7, rs2D = 7 for one cycle -> enF = enD = 0, flushE = 1, stallCycles 0 -> 1. Same stimulus with rdE = 0 -> no stall, counter unchanged.
3. Branch with lwStall: PCSrcE = 1, ResultSrcE = 01, rdE = rs1D = 3 -> flushD = flushE = 1, enF = enD = 1, stallCycles +1.
4. Memory wait: memReqM = 1, memReadyM = 0 for 3 cycles, then 1, with PCSrcE = 1 throughout:
   - during the 3 cycles: enF/enD/enE/enM = 0, flushW = 1, flushD = flushE = 0;
   - on ready: flushD = flushE = 1;
   - state returns to RUN, stallCycles = 3.
5. Timeout with MEM_TIMEOUT = 4: memReqM = 1, memReadyM = 0 held from cycle 0 -> memTimeout = 1 from cycle 5, all en* = 0, stallCycles frozen at 5. memReadyM = 1 later -> remains in ERROR.
6. Reset mid-operation: assert reset for 1 cycle in MEM_WAIT (waitCnt = 2) and again in ERROR -> state RUN, waitCnt 0, memTimeout 0, stallCycles 0. Normal stalls resume afterwards.
